// File: rtl/morse_receiver_pkg.sv
// Shared Morse letter definitions for the transmit and receive ends of the letter link.
// Latency: none (constants, types and a table only).
// Backpressure: none.
// Contents: FRAME_BITS default, receiver state encoding, 16-bit letter frames and 3-bit codes.
package morse_receiver_pkg;

   localparam int FRAME_BITS = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DECODE  = 2'd2
   } state_t;

   // 3-bit letter codes, identical to the transmitter's switch select
   localparam logic [2:0] CODE_A = 3'd0;
   localparam logic [2:0] CODE_B = 3'd1;
   localparam logic [2:0] CODE_C = 3'd2;
   localparam logic [2:0] CODE_D = 3'd3;
   localparam logic [2:0] CODE_E = 3'd4;
   localparam logic [2:0] CODE_F = 3'd5;
   localparam logic [2:0] CODE_G = 3'd6;
   localparam logic [2:0] CODE_H = 3'd7;

   // Frames, first symbol in bit 15 (a dot is 1, a dash is 111, gaps are 0)
   localparam logic [15:0] FRAME_A = 16'hB800;
   localparam logic [15:0] FRAME_B = 16'hEA80;
   localparam logic [15:0] FRAME_C = 16'hEBA0;
   localparam logic [15:0] FRAME_D = 16'hEA00;
   localparam logic [15:0] FRAME_E = 16'h8000;
   localparam logic [15:0] FRAME_F = 16'hAE80;
   localparam logic [15:0] FRAME_G = 16'hEE80;
   localparam logic [15:0] FRAME_H = 16'hAA00;

   // Indexed by letter code
   localparam logic [15:0] LETTER_TABLE [8] = '{
      FRAME_A, FRAME_B, FRAME_C, FRAME_D,
      FRAME_E, FRAME_F, FRAME_G, FRAME_H
   };

endpackage

// File: rtl/morse_lookup.sv
// Combinational frame-to-letter decoder: exact 16-bit match against the letter table.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input continuously.
// Ports: frame in (16), code out (3, 0 when no match), hit out (1 = frame is a letter).
module morse_lookup
   import morse_receiver_pkg::*;
(
   input  logic [15:0] frame,
   output logic [2:0]  code,
   output logic        hit
);

   always_comb begin
      code = 3'd0;
      hit  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (frame == LETTER_TABLE[i]) begin
            code = 3'(i);
            hit  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/morse_receiver.sv
// Morse letter receiver: samples serial_in on Enable ticks, assembles 16-symbol frames, decodes A-H.
// Latency: valid/error pulse one Clock after the edge that samples the 16th symbol.
// Backpressure: none; Enable paces input, clear aborts a partial frame, Enable ignored during DECODE.
// Ports: Clock, Reset_n, Enable, serial_in, clear in; letter(3), valid, error, busy, frame(16) out.
module morse_receiver
   import morse_receiver_pkg::*;
#(
   parameter int FRAME_BITS_P = FRAME_BITS
)
(
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic        Enable,
   input  logic        serial_in,
   input  logic        clear,
   output logic [2:0]  letter,
   output logic        valid,
   output logic        error,
   output logic        busy,
   output logic [15:0] frame
);

   localparam logic [3:0] LAST_COUNT = 4'(FRAME_BITS_P - 1);

   state_t      state;
   logic [15:0] shift;
   logic [3:0]  count;
   logic [2:0]  lookup_code;
   logic        lookup_hit;

   morse_lookup u_lookup (
      .frame (shift),
      .code  (lookup_code),
      .hit   (lookup_hit)
   );

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state  <= ST_IDLE;
         shift  <= 16'h0000;
         count  <= 4'd0;
         letter <= 3'd0;
         frame  <= 16'h0000;
         valid  <= 1'b0;
         error  <= 1'b0;
         busy   <= 1'b0;
      end else begin
         // result pulses last exactly one cycle
         valid <= 1'b0;
         error <= 1'b0;
         if (clear) begin
            // abort wins over Enable and over a pending decode
            state <= ST_IDLE;
            count <= 4'd0;
            busy  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  // zeros between frames are gap; a 1 is always the first symbol
                  if (Enable && serial_in) begin
                     shift <= 16'h0001;
                     count <= 4'd1;
                     state <= ST_CAPTURE;
                     busy  <= 1'b1;
                  end
               end
               ST_CAPTURE: begin
                  if (Enable) begin
                     shift <= {shift[14:0], serial_in};
                     count <= count + 4'd1;
                     if (count == LAST_COUNT) begin
                        state <= ST_DECODE;
                     end
                  end
               end
               ST_DECODE: begin
                  frame <= shift;
                  if (lookup_hit) begin
                     letter <= lookup_code;
                     valid  <= 1'b1;
                  end else begin
                     error <= 1'b1;
                  end
                  count <= 4'd0;
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= ST_IDLE;
                  count <= 4'd0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/morse_receiver.md
Name: morse_receiver

Overview:
- Receive end of the team's Morse letter link: samples a serial on/off stream at the symbol rate and reassembles each 16-symbol frame.
- Decodes the frame to one of letters A–H, with the same 3-bit letter code used on the transmit side's switch select.
- Sits after a symbol-rate tick generator (2 Hz on board, faster in simulation); the serial input comes from a transmitter output or a debounced user key.

Parameters:
- FRAME_BITS, 16, symbols per frame; only 16 is supported by the letter table.

Ports:
- Clock  input  1  system clock (50 MHz on board)
- Reset_n  input  1  asynchronous, active-low reset
- Enable  input  1  symbol tick, one Clock wide; serial_in is sampled only on edges where Enable=1
- serial_in  input  1  received symbol (1 = lit)
- clear  input  1  synchronous abort of a partial frame
- letter  output  3  last decoded letter code: A=000 … H=111
- valid  output  1  one-cycle pulse: frame decoded to a letter
- error  output  1  one-cycle pulse: frame matched no letter
- busy  output  1  high while a frame is being captured or decoded
- frame  output  16  last complete captured frame; first symbol received is in bit 15

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE; shift register, count, letter, frame, valid, error and busy all go to 0.
  - Applies mid-frame too; the partial frame is discarded.
- States: IDLE, CAPTURE, DECODE. All outputs are registered.
- IDLE:
  - Enable=1 and serial_in=0: ignored (inter-frame gap, trailing zeros).
  - Enable=1 and serial_in=1: shift register <= 16'h0001, count <= 1, go to CAPTURE. Every legal frame starts with 1.
- CAPTURE:
  - On each Enable edge: shift register <= {shift[14:0], serial_in}, count <= count+1.
  - The edge that samples the 16th symbol (count=15 before the edge) moves to DECODE.
  - Edges with Enable=0 hold state.
- DECODE (exactly one Clock cycle, independent of Enable):
  - Compare the shift register against the letter table.
  - On the exiting edge: frame <= shift register.
  - Hit: letter <= code, valid <= 1.
  - Miss: letter unchanged, error <= 1.
  - Go to IDLE.
- valid and error:
  - Rise on the first edge after the 16th-sample edge and clear on the following edge.
  - Never both high at once.
- busy = 1 in CAPTURE and DECODE, 0 in IDLE (registered alongside the state).
- An Enable arriving during DECODE is not sampled. Upstream guarantees Enable spacing of at least 2 cycles.
- Letter table (exact 16-bit match):
  - A=16'hB800, B=16'hEA80, C=16'hEBA0, D=16'hEA00
  - E=16'h8000, F=16'hAE80, G=16'hEE80, H=16'hAA00
- clear=1:
  - Next edge: state=IDLE, count=0.
  - letter and frame are untouched; no valid or error pulse.
  - clear beats a simultaneous Enable. clear during DECODE suppresses that frame's pulse.
- count is 4 bits and never wraps in normal operation, since DECODE is forced at 16.
- Back-to-back frames: a 1 on the first Enable after returning to IDLE starts the next frame immediately.

Decomposition:
- Shared package:
  - The eight 16-bit letter constants and their 3-bit codes (shared with the transmit-side character select so both ends use one table).
  - State encoding constants.
  - FRAME_BITS default.
- One combinational sub-module, morse_lookup (frame[15:0] -> code[2:0], hit). Instantiated here; reusable by the transmitter's bench as a checker.
- FSM, shift register and counter stay in morse_receiver.

Test Plan:
- Reset, then 16 Enable ticks (every 4 clocks) carrying 16'hB800 MSB first -> valid pulses once, 1 cycle after the 16th sample; letter=000, frame=16'hB800, busy drops on the same edge.
- Idle zeros, then 16'hAA00, then 16'h8000 back to back -> letter=111 then letter=100; two valid pulses, no error.
- Frame 16'hFFFF -> error pulses once, valid stays 0, letter keeps its prior value, frame=16'hFFFF.
- Start 16'hEBA0, assert clear after 7 symbols, then send 16'hEA00 -> no pulse for the aborted frame; then valid with letter=011.
- Reset_n low after 10 symbols of 16'hEE80 -> all outputs 0 immediately; a fresh 16'hEE80 afterwards -> letter=110, valid.
- Enable held low for 1000 cycles mid-frame -> state and count hold; the frame completes correctly when ticks resume.
